// File: rtl/bmem_wr_arbiter.sv
// bmem_wr_arbiter: round-robin arbiter and sequencer for the bmem write port.
// Optional macro BMEM_ARB_TIMEOUT_EN enables the BUSY timeout abort.
module bmem_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*64-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       req_err,
    input  logic                       bmem_resp,
    output logic                       bmem_wr_en,
    output logic [31:0]                bmem_wr_addr,
    output logic [63:0]                bmem_wr_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       spurious_resp
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              en_q, en_d;
    logic [31:0]       addr_q, addr_d;
    logic [63:0]       data_q, data_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic              err_q, err_d;
    logic              spur_q, spur_d;
    logic [NUM_REQ-1:0] valid_m;
    logic              found;
    int                pick_idx;
    int                scan_idx;
    logic              finish;
    logic              abort;

`ifdef BMEM_ARB_TIMEOUT_EN
    logic [15:0]       cnt_q, cnt_d;
`else
    logic [15:0]       unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

    // The requester just completed is hidden during its done cycle
    assign valid_m = req_valid & ~done_q;

    // Round-robin scan starting at rr_q, wrapping at NUM_REQ
    always_comb begin
        found    = 1'b0;
        pick_idx = 0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ)
                scan_idx = scan_idx - NUM_REQ;
            if (!found && valid_m[scan_idx]) begin
                found    = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/BUSY sequencer
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        en_d    = en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = '0;
        err_d   = 1'b0;
        spur_d  = spur_q;
        finish  = 1'b0;
        abort   = 1'b0;
`ifdef BMEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bmem_resp)
                    spur_d = 1'b1;
                if (found) begin
                    state_d = BUSY;
                    en_d    = 1'b1;
                    owner_d = IW'(pick_idx);
                    addr_d  = req_addr[32*pick_idx +: 32];
                    data_d  = req_data[64*pick_idx +: 64];
`ifdef BMEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (bmem_resp) begin
                    finish = 1'b1;
`ifdef BMEM_ARB_TIMEOUT_EN
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d         = IDLE;
            en_d            = 1'b0;
            addr_d          = '0;
            data_d          = '0;
            done_d[owner_q] = 1'b1;
            err_d           = abort;
            if (owner_q == IW'(NUM_REQ - 1))
                rr_d = '0;
            else
                rr_d = owner_q + 1'b1;
        end
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
`ifdef BMEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
`ifdef BMEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bmem_wr_en    = en_q;
    assign bmem_wr_addr  = addr_q;
    assign bmem_wr_data  = data_q;
    assign busy          = (state_q == BUSY);
    assign owner         = owner_q;
    assign req_done      = done_q;
    assign req_err       = err_q;
    assign spurious_resp = spur_q;

endmodule

// File: doc/bmem_wr_arbiter.md
Name: bmem_wr_arbiter

Overview:
- Round-robin arbiter and sequencer for the single bmem AXI write port.
- Shares the port between NUM_REQ write requesters: the periodic timer uploader, status dumpers and similar.
- Latches the winning request, holds bmem_wr_en/addr/data stable until bmem_resp, then returns a one-cycle done pulse to the owner.
- Sits between the requester blocks and the AXI write master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, maximum BUSY cycles before abort (used only with BMEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request; held until its req_done.
- req_addr  in  NUM_REQ*32  per-requester address; slice i = [32*i+31:32*i].
- req_data  in  NUM_REQ*64  per-requester data; slice i = [64*i+63:64*i].
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_err  out  1  qualifies req_done: 1 = aborted by timeout (option only, else 0).
- bmem_resp  in  1  write response from the AXI master.
- bmem_wr_en  out  1  write request to the AXI master.
- bmem_wr_addr  out  32  write address.
- bmem_wr_data  out  64  write data.
- busy  out  1  1 while a transaction is outstanding.
- owner  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- spurious_resp  out  1  sticky flag: bmem_resp seen while IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE; rr_ptr 0; timeout counter 0.
  - Reset mid-transaction drops bmem_wr_en immediately; the transaction is not completed and no req_done is issued.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - Each cycle, scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins. Latch its addr/data into output registers, set owner.
  - Next edge: state BUSY, bmem_wr_en=1, busy=1.
  - Latency: req_valid sampled high in IDLE at edge t gives bmem_wr_en=1 after edge t.
- BUSY:
  - bmem_wr_en, bmem_wr_addr, bmem_wr_data, owner held constant.
  - Requester input changes, including dropping req_valid, are ignored; the latched transaction completes.
  - On edge where bmem_resp=1: bmem_wr_en←0, busy←0, req_done[owner]←1 for one cycle, rr_ptr←(owner+1) mod NUM_REQ, state IDLE.
- Output values when not BUSY:
  - bmem_wr_addr/bmem_wr_data return to 0 when bmem_wr_en=0; never X.
  - owner keeps its value.
- Done cycle: the completing requester's req_valid is masked from arbitration in the IDLE cycle where its req_done is high, so a requester dropping valid on done is never re-granted.
- Back-to-back: resp at edge t, then done at t..t+1, then next bmem_wr_en=1 after edge t+1. This gives one idle bubble minimum.
- bmem_resp is level-qualified only in BUSY. bmem_resp=1 in IDLE sets spurious_resp (sticky until rst) and has no other effect.
- bmem_resp=1 on the same edge BUSY is entered cannot occur, because en was 0. Any such resp is spurious.
- Fairness: after serving i, requester i has lowest priority. Every continuously-valid requester is granted within NUM_REQ transactions.
- rr_ptr arithmetic wraps at NUM_REQ, including non-power-of-2 values; index NUM_REQ-1 wraps to 0.

Optional Feature:
- Macro: BMEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 without resp: exit to IDLE, bmem_wr_en←0, req_done[owner]←1 with req_err=1, rr_ptr advances.
  - bmem_resp arriving on the same edge as timeout wins as normal completion, with req_err=0.
  - A late resp after abort sets spurious_resp.
- Undefined: no counter; BUSY waits indefinitely; req_err tied 0.

Test Plan:
- Single request: req_valid[2]=1, addr 0x00050000, data 0xDEADBEEF_01234567; resp 3 cycles after en rises -> en high exactly 3 cycles with stable addr/data, req_done=4'b0100 one cycle, then en=0, addr/data=0.
- All four valid continuously, resp 1 cycle after en each time -> grant order 0,1,2,3,0; one idle cycle between transactions; no requester served twice before others.
- Requester 1 drops valid in the same cycle as its done, requester 3 valid -> next grant is 3; requester 1 is not re-granted.
- bmem_resp pulsed while IDLE -> spurious_resp=1 and stays 1; no done, no state change. rst clears it.
- rst asserted asynchronously mid-BUSY -> bmem_wr_en=0 without a clock edge; no req_done; after release, the first grant goes to requester 0.
- With BMEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no resp -> en high 8 cycles, then req_done[owner]=1 with req_err=1, en=0; next requester granted.
